// File: rtl/mac_rx_sched.sv
// Read scheduler for one MAC receive port: arbitrates TTE/BE queues with a bounded
// BE starvation guard, streams accepted frames one byte per cycle, flushes errored frames.
module mac_rx_sched #(
  parameter int MAX_TTE_RUN = 8
) (
  input  logic        clk,
  input  logic        rstn_sys,
  input  logic        ptr_fifo_empty,
  input  logic        tteptr_fifo_empty,
  input  logic [15:0] ptr_fifo_dout,
  input  logic [15:0] tteptr_fifo_dout,
  input  logic [7:0]  data_fifo_dout,
  input  logic [7:0]  tte_fifo_dout,
  output logic        ptr_fifo_rd,
  output logic        tteptr_fifo_rd,
  output logic        data_fifo_rd,
  output logic        tte_fifo_rd,
  input  logic        out_bp,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_tte,
  output logic [12:0] o_len,
  output logic [15:0] cnt_be_frm,
  output logic [15:0] cnt_tte_frm,
  output logic [15:0] cnt_drop
);

  localparam logic [7:0] MAX_RUN = 8'(MAX_TTE_RUN);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_LATCH, S_DATA, S_TAIL} state_t;

  state_t      r_state;
  logic        r_sel;      // 1 = TTE queue owns the current frame
  logic [7:0]  r_tte_run;
  logic [12:0] r_len;
  logic [12:0] r_rem;
  logic        r_drop;
  logic        r_tail;
  logic        r_v1, r_sof1, r_eof1;

  logic        w_gnt_tte, w_gnt_be, w_ptr_rd, w_dat_rd;
  logic [15:0] w_desc;
  logic [12:0] w_len;
  logic [7:0]  w_byte;
  logic        w_unused_bit;

  // BE wins over pending TTE only once TTE has used up its run budget.
  assign w_gnt_tte = ~tteptr_fifo_empty & ~(~ptr_fifo_empty & (r_tte_run == MAX_RUN));
  assign w_gnt_be  = ~ptr_fifo_empty & ~w_gnt_tte;
  assign w_ptr_rd  = ptr_fifo_rd | tteptr_fifo_rd;
  assign w_dat_rd  = data_fifo_rd | tte_fifo_rd;
  assign w_desc    = r_sel ? tteptr_fifo_dout : ptr_fifo_dout;
  assign w_byte    = r_sel ? tte_fifo_dout : data_fifo_dout;
  assign w_len     = w_desc[12:0];
  assign w_unused_bit = w_desc[13];  // reserved descriptor bit

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn_sys) begin
      r_state        <= S_IDLE;
      r_sel          <= 1'b0;
      r_tte_run      <= '0;
      r_len          <= '0;
      r_rem          <= '0;
      r_drop         <= 1'b0;
      r_tail         <= 1'b0;
      r_v1           <= 1'b0;
      r_sof1         <= 1'b0;
      r_eof1         <= 1'b0;
      ptr_fifo_rd    <= 1'b0;
      tteptr_fifo_rd <= 1'b0;
      data_fifo_rd   <= 1'b0;
      tte_fifo_rd    <= 1'b0;
      o_valid        <= 1'b0;
      o_data         <= '0;
      o_sof          <= 1'b0;
      o_eof          <= 1'b0;
      o_tte          <= 1'b0;
      o_len          <= '0;
      cnt_be_frm     <= '0;
      cnt_tte_frm    <= '0;
      cnt_drop       <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      // Stage 1 tracks the read issued last cycle; stage 2 registers the FIFO byte.
      r_v1    <= w_dat_rd;
      r_sof1  <= w_dat_rd & (r_rem == r_len);
      r_eof1  <= w_dat_rd & (r_rem == 13'd1);
      o_valid <= r_v1 & ~r_drop;
      o_sof   <= r_sof1 & ~r_drop;
      o_eof   <= r_eof1 & ~r_drop;
      o_data  <= w_byte;
      o_tte   <= r_sel;
      o_len   <= r_len;

      ptr_fifo_rd    <= 1'b0;
      tteptr_fifo_rd <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!out_bp && (w_gnt_tte || w_gnt_be)) begin
            r_sel          <= w_gnt_tte;
            ptr_fifo_rd    <= w_gnt_be;
            tteptr_fifo_rd <= w_gnt_tte;
            if (w_gnt_be)
              r_tte_run <= '0;
            else if (!ptr_fifo_empty)
              r_tte_run <= r_tte_run + 8'd1;
            r_state <= S_PTR;
          end
        end
        S_PTR: begin
          // First PTR cycle is the pop itself; the descriptor is readable one cycle later.
          if (!w_ptr_rd) r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_len  <= w_len;
          r_drop <= w_desc[14] | w_desc[15] | (w_len == 13'd0);
          if (w_len == 13'd0) begin
            cnt_drop <= sat_inc(cnt_drop);
            r_state  <= S_IDLE;
          end else begin
            data_fifo_rd <= ~r_sel;
            tte_fifo_rd  <= r_sel;
            r_rem        <= w_len;
            r_state      <= S_DATA;
          end
        end
        S_DATA: begin
          r_rem <= r_rem - 13'd1;
          if (r_rem == 13'd1) begin
            data_fifo_rd <= 1'b0;
            tte_fifo_rd  <= 1'b0;
            r_tail       <= 1'b0;
            r_state      <= S_TAIL;
            if (r_drop)     cnt_drop    <= sat_inc(cnt_drop);
            else if (r_sel) cnt_tte_frm <= sat_inc(cnt_tte_frm);
            else            cnt_be_frm  <= sat_inc(cnt_be_frm);
          end
        end
        S_TAIL: begin
          r_tail <= 1'b1;
          if (r_tail) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
